// File: rtl/pump_pkg.sv
// Shared types and default timing for the drain-pump sequencer.
package pump_pkg;

    typedef enum logic [1:0] {
        OFF_WAIT = 2'b00,
        IDLE     = 2'b01,
        RUN      = 2'b10,
        FAULT    = 2'b11
    } pump_state_e;

    localparam int unsigned DEF_CLK_HZ        = 1000;
    localparam int unsigned DEF_TICK_HZ       = 2;
    localparam int unsigned DEF_LVL_W         = 8;
    localparam int unsigned DEF_MIN_RUN_TICKS = 10;
    localparam int unsigned DEF_MIN_OFF_TICKS = 6;
    localparam int unsigned DEF_MAX_RUN_TICKS = 120;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a single-cycle tick enable every CLK_HZ/TICK_HZ cycles.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 1000,
    parameter int unsigned TICK_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Count 0..DIV-1; tick is registered so it is high while cnt holds the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == CNT_W'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            tick <= (cnt == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/pump_sequencer.sv
// Drain-pump sequencer: level hysteresis, min run/off times, run timeout fault, alarm LED.
module pump_sequencer
    import pump_pkg::*;
#(
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ       = DEF_TICK_HZ,
    parameter int unsigned LVL_W         = DEF_LVL_W,
    parameter int unsigned MIN_RUN_TICKS = DEF_MIN_RUN_TICKS,
    parameter int unsigned MIN_OFF_TICKS = DEF_MIN_OFF_TICKS,
    parameter int unsigned MAX_RUN_TICKS = DEF_MAX_RUN_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] level,
    input  logic [LVL_W-1:0] lo_th,
    input  logic [LVL_W-1:0] hi_th,
    input  logic             fault_clr,
    output logic             pump_on,
    output logic             alarm_led,
    output logic             fault,
    output logic             cfg_err,
    output logic [1:0]       state
);

    localparam int unsigned TCNT_W = $clog2(MAX_RUN_TICKS + 1);

    pump_state_e       state_q;
    pump_state_e       state_d;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W-1:0] tcnt_d;
    logic              pump_on_d;
    logic              alarm_d;
    logic              fault_d;
    logic              tick;
    logic              high_water;

    assign state      = state_q;
    assign high_water = (level >= hi_th);

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // State, tick counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF_WAIT;
            tcnt      <= '0;
            pump_on   <= 1'b0;
            alarm_led <= 1'b0;
            fault     <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt      <= tcnt_d;
            pump_on   <= pump_on_d;
            alarm_led <= alarm_d;
            fault     <= fault_d;
            cfg_err   <= (lo_th >= hi_th);
        end
    end

    // Next state, tick counter and output values from the current registered state.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt;
        pump_on_d = 1'b0;
        alarm_d   = 1'b0;
        fault_d   = 1'b0;

        case (state_q)
            OFF_WAIT: begin
                if (tcnt >= TCNT_W'(MIN_OFF_TICKS)) state_d = IDLE;
            end
            IDLE: begin
                if (high_water && !cfg_err) state_d = RUN;
            end
            RUN: begin
                // A normal stop outranks the timeout when both hold in one cycle.
                if (cfg_err) begin
                    state_d = OFF_WAIT;
                end else if ((level <= lo_th) && (tcnt >= TCNT_W'(MIN_RUN_TICKS))) begin
                    state_d = OFF_WAIT;
                end else if (tcnt == TCNT_W'(MAX_RUN_TICKS)) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (fault_clr) state_d = OFF_WAIT;
            end
            default: state_d = OFF_WAIT;
        endcase

        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick && (tcnt != TCNT_W'(MAX_RUN_TICKS))) begin
            tcnt_d = tcnt + TCNT_W'(1);
        end

        pump_on_d = (state_d == RUN);
        fault_d   = (state_d == FAULT);

        case (state_d)
            FAULT: begin
                if (state_q != FAULT) alarm_d = 1'b1;
                else                  alarm_d = alarm_led ^ tick;
            end
            OFF_WAIT, IDLE: begin
                // Leaving FAULT clears the LED for one cycle before the level rule resumes.
                alarm_d = (state_q == FAULT) ? 1'b0 : high_water;
            end
            default: alarm_d = 1'b0;
        endcase
    end

endmodule
